// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state numbering, address width and R/W bit values.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ACK_ADDR  = 4'd2,
    ST_RX        = 4'd3,
    ST_ACK_RX    = 4'd4,
    ST_TX        = 4'd5,
    ST_ACK_TX    = 4'd6,
    ST_WAIT_STOP = 4'd7
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_p_q;
  logic                   sda_p_q;
  logic                   scl_s;

  // Flops reset to the idle bus level so leaving reset never looks like a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = ~scl_p_q & scl_s;
  assign scl_fall  = scl_p_q & ~scl_s;
  assign start_det = scl_p_q & scl_s & sda_p_q & ~sda_s;
  assign stop_det  = scl_p_q & scl_s & ~sda_p_q & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: address match, byte receive and byte serve over a one-byte handshake.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h77,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic [3:0] state
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= I2C_WRITE;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= '0;
              if (shift_q[7:1] == TARGET_ADDR) begin
                state_q  <= ST_ACK_ADDR;
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                rw_q     <= shift_q[0];
                tx_req_q <= (shift_q[0] == I2C_READ);
              end else begin
                state_q  <= ST_WAIT_STOP;
                sda_oe_q <= 1'b0;
              end
            end
          end
          ST_ACK_ADDR: begin
            if (scl_fall) begin
              if (rw_q == I2C_READ) begin
                shift_q   <= tx_data;
                sda_oe_q  <= ~tx_data[7];
                bit_cnt_q <= 4'd1;
                state_q   <= ST_TX;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= ST_RX;
              end
            end
          end
          ST_RX: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                rx_data_q  <= {shift_q[6:0], sda_s};
                rx_valid_q <= 1'b1;
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              sda_oe_q  <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= ST_ACK_RX;
            end
          end
          ST_ACK_RX: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_RX;
            end
          end
          // bit_cnt_q counts bits already placed on the bus; shift_q[7] is the bit on the wire.
          ST_TX: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= ST_ACK_TX;
              end else begin
                shift_q   <= {shift_q[6:0], 1'b0};
                sda_oe_q  <= ~shift_q[6];
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          ST_ACK_TX: begin
            if (scl_rise) begin
              if (sda_s == 1'b0) begin
                tx_req_q <= 1'b1;
              end else begin
                state_q <= ST_WAIT_STOP;
                busy_q  <= 1'b0;
              end
            end else if (scl_fall) begin
              shift_q   <= tx_data;
              sda_oe_q  <= ~tx_data[7];
              bit_cnt_q <= 4'd1;
              state_q   <= ST_TX;
            end
          end
          ST_WAIT_STOP: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged I2C master, transaction table plus random transactions.
module tb_i2c_target_responder;

  localparam logic [6:0] ADDR = 7'h77;
  localparam int         Q    = 8;   // clk cycles per quarter SCL period

  logic       clk;
  logic       rst;
  logic       scl;
  logic       msda;
  logic       ovr_en;
  logic       ovr_val;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;
  logic [3:0] state;

  assign sda_in = ovr_en ? ovr_val : (msda & ~sda_oe);

  i2c_target_responder #(.TARGET_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    int          n;
    logic [31:0] bytes;
    logic        stop;
    logic        exp_match;
    int          exp_rx;
    int          exp_txreq;
  } txn_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];
  int         txreq_cnt = 0;
  logic       oe_seen = 1'b0;

  // Target-side handshake partner: collect received bytes, serve queued read bytes.
  always @(negedge clk) begin
    if (rx_valid) rx_got.push_back(rx_data);
    if (tx_req) begin
      txreq_cnt++;
      if (tx_q.size() > 0) tx_data = tx_q.pop_front();
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    msda = 1'b1; wq();
    scl  = 1'b1; wq();
    msda = 1'b0; wq();
    scl  = 1'b0; wq();
  endtask

  task automatic m_stop();
    msda = 1'b0; wq();
    scl  = 1'b1; wq();
    msda = 1'b1; wq();
    wq();
  endtask

  task automatic m_clock(input logic b, output logic s);
    msda = b;    wq();
    scl  = 1'b1; wq();
    s    = sda_in; wq();
    scl  = 1'b0; wq();
  endtask

  task automatic m_write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_clock(b[i], s);
    m_clock(1'b1, ack);
  endtask

  task automatic m_read_byte(input logic nack, output logic [7:0] r);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_clock(1'b1, s);
      r[i] = s;
    end
    m_clock(nack, s);
  endtask

  // Transaction-level expectation: only the matching address is served, every byte of it.
  function automatic txn_t model(input logic [6:0] a, input logic rw, input int n,
                                 input logic [31:0] bytes);
    txn_t t;
    t.addr      = a;
    t.rw        = rw;
    t.n         = n;
    t.bytes     = bytes;
    t.stop      = 1'b1;
    t.exp_match = (a == ADDR);
    t.exp_rx    = (t.exp_match && !rw) ? n : 0;
    t.exp_txreq = (t.exp_match && rw) ? n : 0;
    return t;
  endfunction

  task automatic run_txn(input string tag, input txn_t t);
    logic       ack;
    logic [7:0] b, r;
    rx_got.delete();
    tx_q.delete();
    txreq_cnt = 0;
    oe_seen   = 1'b0;
    if (t.rw) for (int i = 0; i < t.n; i++) tx_q.push_back(t.bytes[31-8*i -: 8]);
    m_start();
    check({tag, "_state_start"}, 32'(state), 32'd1);
    check({tag, "_busy_start"}, 32'(busy), 32'd0);
    m_write_byte({t.addr, t.rw}, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'(!t.exp_match));
    check({tag, "_busy_addr"}, 32'(busy), 32'(t.exp_match));
    for (int i = 0; i < t.n; i++) begin
      b = t.bytes[31-8*i -: 8];
      if (!t.rw) begin
        m_write_byte(b, ack);
        check($sformatf("%s_wr_ack%0d", tag, i), 32'(ack), 32'(!t.exp_match));
      end else begin
        m_read_byte(i == t.n - 1, r);
        check($sformatf("%s_rd_byte%0d", tag, i), 32'(r), t.exp_match ? 32'(b) : 32'hFF);
      end
    end
    check({tag, "_state_end"}, 32'(state), (t.exp_match && !t.rw) ? 32'd3 : 32'd7);
    check({tag, "_busy_end"}, 32'(busy), 32'(t.exp_match && !t.rw));
    if (t.stop) begin
      m_stop();
      check({tag, "_state_stop"}, 32'(state), 32'd0);
      check({tag, "_busy_stop"}, 32'(busy), 32'd0);
      check({tag, "_oe_stop"}, 32'(sda_oe), 32'd0);
    end
    check({tag, "_rx_count"}, 32'(rx_got.size()), 32'(t.exp_rx));
    for (int i = 0; i < rx_got.size() && i < t.exp_rx; i++)
      check($sformatf("%s_rx_data%0d", tag, i), 32'(rx_got[i]), 32'(t.bytes[31-8*i -: 8]));
    check({tag, "_txreq_count"}, 32'(txreq_cnt), 32'(t.exp_txreq));
    check({tag, "_oe_seen"}, 32'(oe_seen), 32'(t.exp_match));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t       tbl[6];
    txn_t       t;
    logic       s;
    logic [6:0] a;
    int         cyc;

    tbl[0] = '{addr:7'h77, rw:1'b0, n:2, bytes:32'hA53C_0000, stop:1'b1, exp_match:1'b1, exp_rx:2, exp_txreq:0};
    tbl[1] = '{addr:7'h77, rw:1'b1, n:2, bytes:32'h1234_0000, stop:1'b1, exp_match:1'b1, exp_rx:0, exp_txreq:2};
    tbl[2] = '{addr:7'h50, rw:1'b0, n:1, bytes:32'hAA00_0000, stop:1'b1, exp_match:1'b0, exp_rx:0, exp_txreq:0};
    tbl[3] = '{addr:7'h77, rw:1'b0, n:1, bytes:32'h5A00_0000, stop:1'b0, exp_match:1'b1, exp_rx:1, exp_txreq:0};
    tbl[4] = '{addr:7'h77, rw:1'b1, n:2, bytes:32'hC381_0000, stop:1'b1, exp_match:1'b1, exp_rx:0, exp_txreq:2};
    tbl[5] = '{addr:7'h50, rw:1'b1, n:1, bytes:32'h0F00_0000, stop:1'b1, exp_match:1'b0, exp_rx:0, exp_txreq:0};

    rst = 1'b1; scl = 1'b1; msda = 1'b1; ovr_en = 1'b0; ovr_val = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_pulses", {30'd0, rx_valid, tx_req}, 32'd0);
    rst = 1'b0;
    wq();

    // Row 3 leaves the bus open so row 4 begins with a repeated START.
    for (int i = 0; i < 6; i++) run_txn($sformatf("t%0d", i), tbl[i]);

    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom_range(0, 127));
      t = model(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom);
      run_txn($sformatf("r%0d", i), t);
    end

    // STOP in the middle of a read byte while the target is pulling SDA low.
    tx_q.delete();
    tx_q.push_back(8'h00);
    m_start();
    m_write_byte({ADDR, 1'b1}, s);
    check("stopmid_addr_ack", 32'(s), 32'd0);
    for (int i = 0; i < 3; i++) begin
      m_clock(1'b1, s);
      check($sformatf("stopmid_bit%0d", i), 32'(s), 32'd0);
    end
    check("stopmid_state_tx", 32'(state), 32'd5);
    check("stopmid_oe_driving", 32'(sda_oe), 32'd1);
    scl = 1'b1; wq();
    ovr_val = 1'b0; ovr_en = 1'b1;
    @(posedge clk); #1;
    ovr_val = 1'b1;
    cyc = 0;
    for (int k = 0; k < 8 && state != 4'd0; k++) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stopmid_latency", 32'(cyc), 32'd3);
    check("stopmid_state", 32'(state), 32'd0);
    check("stopmid_oe", 32'(sda_oe), 32'd0);
    check("stopmid_busy", 32'(busy), 32'd0);
    ovr_en = 1'b0;
    wq();

    // Reset while the target is driving the address ACK.
    m_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = {ADDR, 1'b0};
      m_clock(ab[i], s);
    end
    msda = 1'b1; wq();
    check("rstmid_state_ack", 32'(state), 32'd2);
    check("rstmid_oe_before", 32'(sda_oe), 32'd1);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_oe", 32'(sda_oe), 32'd0);
    check("rstmid_state", 32'(state), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rx_data", 32'(rx_data), 32'd0);
    check("rstmid_pulses", {30'd0, rx_valid, tx_req}, 32'd0);
    rst = 1'b0;
    wq();
    scl = 1'b1; wq();
    wq();
    run_txn("post_rst", model(ADDR, 1'b0, 1, 32'h9600_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) end of the on-board sensor bus. Answers the existing I2C master interface and lets the bench and hardware-in-loop rigs emulate a sensor.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address and ACKs it. Receives write bytes and serves read bytes through a byte-wide handshake.
- Drives SDA open-drain only: it can pull low or release.

Parameters:
- TARGET_ADDR, 7'h77, 7-bit bus address this block answers.
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL pin level.
- sda_in  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low; 0 = release. Pad logic implements SDA = sda_oe ? 0 : z.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- tx_data  input  8  next byte to return on a read.
- tx_req  output  1  one-clk pulse requesting the next tx_data.
- busy  output  1  high from an address-matched START until STOP/NACK.
- state  output  4  current FSM state, for debug.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state=IDLE, shift registers cleared. Reset mid-transfer releases SDA on the next clk.
- Bus sampling: scl_s/sda_s come from SYNC_STAGES flops, plus a one-clk-delayed copy of each.
  - SCL rise = prev 0, now 1. SCL fall = prev 1, now 0.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - START/STOP take priority over data edges in the same clk.
- Bit order is MSB first. Data is sampled on SCL rise. sda_oe changes only on the clk after an SCL fall.
- States (4-bit encoding): IDLE=0, ADDR=1, ACK_ADDR=2, RX=3, ACK_RX=4, TX=5, ACK_TX=6, WAIT_STOP=7.
- IDLE: START -> ADDR with bit counter cleared.
- ADDR: shift in 8 bits (7 address bits + R/W).
  - After the 8th SCL fall: on address match -> ACK_ADDR, sda_oe=1, busy=1. No match -> WAIT_STOP with sda_oe=0.
- ACK_ADDR: sda_oe is held through the 9th clock.
  - On a read, tx_req pulses on the clk ACK_ADDR is entered.
  - On the 9th SCL fall: write -> RX with sda_oe=0. Read -> TX, tx_data is latched into the shift register and sda_oe = ~tx_data[7].
- RX: after 8 SCL rises, rx_data is loaded and rx_valid pulses on that clk. On the following SCL fall -> ACK_RX with sda_oe=1. Every byte is ACKed; there is no overflow flagging.
- ACK_RX: on SCL fall, release SDA -> RX.
- TX: on each SCL fall, sda_oe = ~next bit. After the 8th bit's SCL fall, sda_oe=0 -> ACK_TX.
- ACK_TX: the master's ACK is sampled on SCL rise.
  - ACK (0): tx_req pulses on that clk. On the next SCL fall, tx_data is latched and the next byte starts -> TX.
  - NACK (1): -> WAIT_STOP.
- tx_data must be stable from the tx_req pulse until the next SCL fall (about half an SCL period later).
- WAIT_STOP: SDA released and busy=0. Data edges are ignored.
- Any state: STOP -> IDLE, sda_oe=0, busy=0. Repeated START -> ADDR, sda_oe=0, busy=0. Both outrank all other transitions.
- Before sda_in is compared, the block never interprets its own sda_oe; the bus wired-AND is external.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings (IDLE..WAIT_STOP), shared with the master's state numbering style;
  - constant I2C_ADDR_W=7;
  - constants for the READ/WRITE bit values.
- Sub-module i2c_bus_sync: synchroniser plus edge/START/STOP detector. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s. It is reusable by the master.

Test Plan:
- Write to 0x77 (addr byte 0xEE) with data 0xA5, 0x3C, then STOP. Expected:
  - ACK on the address and both bytes;
  - rx_valid pulses twice with rx_data=0xA5 then 0x3C;
  - busy falls at STOP.
- Read from 0x77 (0xEF), tx_data supplied as 0x12 then 0x34, master ACKs then NACKs. Expected:
  - the bus carries bits 0x12 then 0x34;
  - tx_req pulses twice;
  - state=WAIT_STOP after the NACK and IDLE after STOP.
- Address 0x50 written. Expected: no ACK (SDA high on the 9th clock), sda_oe never asserted, rx_valid never pulses.
- Write 0x77 with one byte, repeated START, read 0x77. Expected: state returns to ADDR at the restart and the read completes correctly.
- STOP issued mid-byte during TX. Expected: sda_oe=0 within 1 clk of detection, state=IDLE.
- rst asserted while sda_oe=1 in ACK_ADDR. Expected: sda_oe=0 and all outputs 0 on the next clk; a subsequent clean write ACKs normally.
